// File: rtl/product_bcd_conv_if.sv
// Handshake bundle between the multiplier, the BCD converter and the HEX driver.
// blank_out exists only when BCD_LEADING_BLANK_EN is defined.
interface product_bcd_conv_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic [WIDTH-1:0]    p_in;
    logic                p_valid;
    logic                p_ready;
    logic [4*DIGITS-1:0] bcd_out;
    logic                bcd_valid;
    logic                bcd_ready;
`ifdef BCD_LEADING_BLANK_EN
    logic [DIGITS-1:0]   blank_out;
`endif

    // Environment side: supplies the product and consumes the BCD result.
    modport master (
        output p_in,
        output p_valid,
        output bcd_ready,
        input  p_ready,
        input  bcd_out,
`ifdef BCD_LEADING_BLANK_EN
        input  blank_out,
`endif
        input  bcd_valid
    );

    // Converter side.
    modport slave (
        input  p_in,
        input  p_valid,
        input  bcd_ready,
        output p_ready,
        output bcd_out,
`ifdef BCD_LEADING_BLANK_EN
        output blank_out,
`endif
        output bcd_valid
    );
endinterface

// File: rtl/product_bcd_conv.sv
// Sequential double-dabble converter: binary product -> packed BCD, one shift per clock.
// Optional leading-zero blank flags are enabled with BCD_LEADING_BLANK_EN.
module product_bcd_conv #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3,
    parameter int CNT_W  = 4
) (
    input  logic                clk,
    input  logic                resetn,
    product_bcd_conv_if.slave   bus
);

    localparam int SW = 4 * DIGITS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    generate
        if ((10 ** DIGITS) <= ((2 ** WIDTH) - 1)) begin : g_digits_chk
            $fatal(1, "product_bcd_conv: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
        end
        if ((2 ** CNT_W) <= WIDTH) begin : g_cnt_chk
            $fatal(1, "product_bcd_conv: CNT_W=%0d cannot hold WIDTH=%0d", CNT_W, WIDTH);
        end
    endgenerate

    logic [1:0]       state;
    logic [WIDTH-1:0] bin_q;
    logic [SW-1:0]    scr_q;
    logic [CNT_W-1:0] cnt_q;
    logic [SW-1:0]    bcd_q;

    logic [SW-1:0]    scr_adj;
    logic [SW-1:0]    scr_nx;
    logic [WIDTH-1:0] bin_nx;
    logic             last_shift;

    // Add 3 to every digit holding 5..9 so the following shift carries correctly.
    function automatic logic [SW-1:0] add3_correct(input logic [SW-1:0] s);
        logic [SW-1:0] r;
        logic [3:0]    d;
        r = s;
        for (int i = 0; i < DIGITS; i++) begin
            d = s[4*i +: 4];
            if (d >= 4'd5) begin
                r[4*i +: 4] = d + 4'd3;
            end
        end
        return r;
    endfunction

    assign scr_adj          = add3_correct(scr_q);
    assign {scr_nx, bin_nx} = {scr_adj, bin_q} << 1;
    assign last_shift       = (cnt_q == CNT_W'(WIDTH - 1));

    assign bus.p_ready   = (state == S_IDLE);
    assign bus.bcd_valid = (state == S_DONE);
    assign bus.bcd_out   = bcd_q;

`ifdef BCD_LEADING_BLANK_EN
    logic [DIGITS-1:0] blank_q;

    // Digit i is blank when it and all higher digits are zero; the ones digit always shows.
    function automatic logic [DIGITS-1:0] leading_blank(input logic [SW-1:0] s);
        logic [DIGITS-1:0] b;
        logic              all_zero;
        b        = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            all_zero = all_zero && (s[4*i +: 4] == 4'd0);
            b[i]     = all_zero;
        end
        return b;
    endfunction

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            blank_q <= '0;
        end else if (state == S_SHIFT && last_shift) begin
            blank_q <= leading_blank(scr_nx);
        end
    end

    assign bus.blank_out = blank_q;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            bin_q <= '0;
            scr_q <= '0;
            cnt_q <= '0;
            bcd_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.p_valid) begin
                        bin_q <= bus.p_in;
                        scr_q <= '0;
                        cnt_q <= '0;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    bin_q <= bin_nx;
                    scr_q <= scr_nx;
                    cnt_q <= cnt_q + 1'b1;
                    if (last_shift) begin
                        bcd_q <= scr_nx;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.bcd_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_product_bcd_conv.sv
// Directed bench for product_bcd_conv: handshake, latency, stall, async reset and a full sweep.
module tb_product_bcd_conv;
    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;
    localparam int CNT_W  = 4;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    int   errors = 0;
    int   checks = 0;

    product_bcd_conv_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    product_bcd_conv #(.WIDTH(WIDTH), .DIGITS(DIGITS), .CNT_W(CNT_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] ref_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [2:0] ref_blank(input int v);
        return {v < 100, v < 10, 1'b0};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present v until accepted, then count edges until bcd_valid rises.
    task automatic convert(input logic [7:0] v, output int lat);
        bit acc;
        int guard;
        bus.p_in    = v;
        bus.p_valid = 1'b1;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 50) begin
            acc = bus.p_ready;
            tick(1);
            guard++;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        bus.p_valid = 1'b0;
        lat = 0;
        while (!bus.bcd_valid && lat < 40) begin
            tick(1);
            lat++;
        end
    endtask

    task automatic chk_blank(input string tag, input int v);
`ifdef BCD_LEADING_BLANK_EN
        chk(tag, 32'(bus.blank_out), 32'(ref_blank(v)));
`else
        chk(tag, 32'(bus.bcd_out), 32'(ref_bcd(v)));
`endif
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  stable;
        bus.p_in      = '0;
        bus.p_valid   = 1'b0;
        bus.bcd_ready = 1'b1;

        // Reset state
        #1 resetn = 1'b0;
        #21;
        chk("rst_p_ready",   32'(bus.p_ready),   32'd1);
        chk("rst_bcd_valid", 32'(bus.bcd_valid), 32'd0);
        chk("rst_bcd_out",   32'(bus.bcd_out),   32'h000);
        resetn = 1'b1;
        tick(1);

        // Zero input
        convert(8'd0, lat);
        chk("zero_out", 32'(bus.bcd_out), 32'h000);
        chk("zero_lat", 32'(lat), 32'd8);
        chk_blank("zero_blank", 0);
        tick(1);

        // 255 with downstream always ready
        convert(8'd255, lat);
        chk("ff_out",   32'(bus.bcd_out),   32'h255);
        chk("ff_lat",   32'(lat),           32'd8);
        chk("ff_valid", 32'(bus.bcd_valid), 32'd1);
        chk_blank("ff_blank", 255);
        tick(1);
        chk("ff_valid_1cyc", 32'(bus.bcd_valid), 32'd0);
        chk("ff_p_ready",    32'(bus.p_ready),   32'd1);
        chk("ff_out_retain", 32'(bus.bcd_out),   32'h255);

        // 225 then 9 back-to-back with p_valid held
        bus.p_in    = 8'd225;
        bus.p_valid = 1'b1;
        tick(1);
        bus.p_in = 8'd9;
        chk("b2b_busy", 32'(bus.p_ready), 32'd0);
        tick(7);
        chk("b2b_not_early", 32'(bus.bcd_valid), 32'd0);
        tick(1);
        chk("b2b_valid1", 32'(bus.bcd_valid), 32'd1);
        chk("b2b_out1",   32'(bus.bcd_out),   32'h225);
        tick(1);
        chk("b2b_idle",   32'(bus.p_ready),   32'd1);
        chk("b2b_vld0",   32'(bus.bcd_valid), 32'd0);
        tick(1);
        chk("b2b_accept2", 32'(bus.p_ready), 32'd0);
        bus.p_valid = 1'b0;
        tick(7);
        chk("b2b_not_early2", 32'(bus.bcd_valid), 32'd0);
        tick(1);
        chk("b2b_valid2", 32'(bus.bcd_valid), 32'd1);
        chk("b2b_out2",   32'(bus.bcd_out),   32'h009);
        chk_blank("b2b_blank2", 9);
        tick(1);

        // Downstream stall with 100, new request ignored meanwhile
        bus.bcd_ready = 1'b0;
        convert(8'd100, lat);
        chk("stall_out", 32'(bus.bcd_out), 32'h100);
        chk("stall_lat", 32'(lat),         32'd8);
        chk_blank("stall_blank", 100);
        bus.p_in    = 8'd7;
        bus.p_valid = 1'b1;
        stable = 1'b1;
        repeat (20) begin
            tick(1);
            if (!(bus.bcd_valid === 1'b1 && bus.bcd_out === 12'h100 && bus.p_ready === 1'b0))
                stable = 1'b0;
        end
        chk("stall_hold", 32'(stable), 32'd1);
        bus.bcd_ready = 1'b1;
        tick(1);
        chk("stall_release_idle", 32'(bus.p_ready),   32'd1);
        chk("stall_release_vld",  32'(bus.bcd_valid), 32'd0);
        tick(1);
        chk("stall_accept7", 32'(bus.p_ready), 32'd0);
        bus.p_valid = 1'b0;
        tick(8);
        chk("seven_valid", 32'(bus.bcd_valid), 32'd1);
        chk("seven_out",   32'(bus.bcd_out),   32'h007);
        tick(1);

        // Asynchronous reset in the middle of converting 200
        bus.p_in    = 8'd200;
        bus.p_valid = 1'b1;
        tick(1);
        bus.p_valid = 1'b0;
        tick(3);
        #2 resetn = 1'b0;
        #1;
        chk("arst_p_ready",   32'(bus.p_ready),   32'd1);
        chk("arst_bcd_valid", 32'(bus.bcd_valid), 32'd0);
        chk("arst_bcd_out",   32'(bus.bcd_out),   32'h000);
`ifdef BCD_LEADING_BLANK_EN
        chk("arst_blank", 32'(bus.blank_out), 32'd0);
`endif
        #3 resetn = 1'b1;
        tick(1);
        convert(8'd42, lat);
        chk("post_rst_out", 32'(bus.bcd_out), 32'h042);
        chk("post_rst_lat", 32'(lat),         32'd8);
        chk_blank("post_rst_blank", 42);
        tick(1);

        // Full sweep against the decimal model
        for (int v = 0; v < 256; v++) begin
            convert(8'(v), lat);
            chk($sformatf("sweep_out_%0d", v), 32'(bus.bcd_out), 32'(ref_bcd(v)));
            chk($sformatf("sweep_lat_%0d", v), 32'(lat),         32'd8);
`ifdef BCD_LEADING_BLANK_EN
            chk($sformatf("sweep_blank_%0d", v), 32'(bus.blank_out), 32'(ref_blank(v)));
`endif
            tick(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
